// File: rtl/spi_slave_if.sv
// Pin and FIFO bundle for spi_slave: TX pull side, RX push side, SPI pins and error pulses.
interface spi_slave_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] in;
  logic         get;
  logic         empty;
  logic [W-1:0] out;
  logic         put;
  logic         full;
  logic         spi_cs_n;
  logic         spi_clock;
  logic         spi_mosi;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic         overrun;
  logic         underrun;

  modport slave (
    input  in, empty, full, spi_cs_n, spi_clock, spi_mosi,
    output get, out, put, spi_miso, spi_miso_oe, overrun, underrun
  );

  modport master (
    output in, empty, full, spi_cs_n, spi_clock, spi_mosi,
    input  get, out, put, spi_miso, spi_miso_oe, overrun, underrun
  );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, MSB first, oversampling the SPI pins in the system clock domain.
// Pulls TX words through a one-word holding register and pushes each received word to the RX FIFO.
module spi_slave #(
  parameter int unsigned   W    = 8,
  parameter logic [W-1:0]  IDLE = '1
) (
  input  logic          clock,
  input  logic          reset,
  spi_slave_if.slave    bus
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_cs_meta, r_cs_sync, r_cs_prev;
  logic          r_sck_meta, r_sck_sync, r_sck_prev;
  logic          r_mosi_meta, r_mosi_sync;
  logic [W-1:0]  r_hold;
  logic          r_hold_valid;
  logic          r_get;
  logic [W-1:0]  r_shift;
  logic [W-2:0]  r_rx;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_out;
  logic          r_put;
  logic          r_miso_oe;
  logic          r_overrun;
  logic          r_underrun;

  logic          w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
  logic          w_load;
  logic [W-1:0]  w_load_word;
  logic [W-1:0]  w_rx_word;

  assign w_cs_fall   = r_cs_prev & ~r_cs_sync;
  assign w_cs_rise   = ~r_cs_prev & r_cs_sync;
  assign w_sck_rise  = ~r_sck_prev & r_sck_sync;
  assign w_sck_fall  = r_sck_prev & ~r_sck_sync;
  assign w_rx_word   = {r_rx, r_mosi_sync};
  assign w_load_word = r_hold_valid ? r_hold : IDLE;

  // Word load: on select, or on the first falling SCK after a completed word while still selected.
  assign w_load = ((r_state == ST_IDLE) && w_cs_fall) ||
                  ((r_state == ST_ACTIVE) && !w_cs_rise && w_sck_fall && (r_count == '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_SYNC;
      r_cs_meta    <= 1'b0;
      r_cs_sync    <= 1'b0;
      r_cs_prev    <= 1'b0;
      r_sck_meta   <= 1'b0;
      r_sck_sync   <= 1'b0;
      r_sck_prev   <= 1'b0;
      r_mosi_meta  <= 1'b0;
      r_mosi_sync  <= 1'b0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_get        <= 1'b0;
      r_shift      <= '0;
      r_rx         <= '0;
      r_count      <= '0;
      r_out        <= '0;
      r_put        <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_overrun    <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_cs_meta   <= bus.spi_cs_n;
      r_cs_sync   <= r_cs_meta;
      r_cs_prev   <= r_cs_sync;
      r_sck_meta  <= bus.spi_clock;
      r_sck_sync  <= r_sck_meta;
      r_sck_prev  <= r_sck_sync;
      r_mosi_meta <= bus.spi_mosi;
      r_mosi_sync <= r_mosi_meta;

      r_get      <= ~r_hold_valid & ~bus.empty & ~r_get;
      r_put      <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;

      if (w_load) begin
        r_shift <= w_load_word;
        if (r_hold_valid) r_hold_valid <= 1'b0;
        else              r_underrun   <= 1'b1;
      end

      // A pop always refills the holding register; it can only occur while the register is empty.
      if (r_get) begin
        r_hold       <= bus.in;
        r_hold_valid <= 1'b1;
      end

      case (r_state)
        ST_SYNC: begin
          if (r_cs_sync) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= ST_ACTIVE;
            r_count   <= '0;
            r_miso_oe <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_shift   <= '0;
            r_miso_oe <= 1'b0;
          end else if (w_sck_rise) begin
            r_rx <= w_rx_word[W-2:0];
            if (r_count == CW'(W - 1)) begin
              r_count <= '0;
              if (!bus.full) begin
                r_out <= w_rx_word;
                r_put <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_count <= CW'(r_count + 1'b1);
            end
          end else if (w_sck_fall && (r_count != '0)) begin
            r_shift <= {r_shift[W-2:0], 1'b0};
          end
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign bus.get         = r_get;
  assign bus.out         = r_out;
  assign bus.put         = r_put;
  assign bus.spi_miso    = r_shift[W-1];
  assign bus.spi_miso_oe = r_miso_oe;
  assign bus.overrun     = r_overrun;
  assign bus.underrun    = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a mode-0 SPI master at clk/8 plus TX/RX FIFO models.
module tb_spi_slave;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_if #(.W(W)) bus ();

  spi_slave #(.W(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [7:0] tx_q[$];
  logic [7:0] exp_rx[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_under  = 0;
  int n_over   = 0;
  int n_get    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // TX FIFO model: pop on the edge where get is high
  always @(posedge clk) begin
    if (bus.get && tx_q.size() > 0) void'(tx_q.pop_front());
  end

  // FIFO flags, pulse counters and the RX scoreboard, all away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.get) begin
        n_get++;
        check("get_while_empty", 32'(bus.empty), 0);
      end
      if (bus.underrun) n_under++;
      if (bus.overrun)  n_over++;
      if (bus.put) begin
        check("put_expected", 32'(exp_rx.size() > 0), 1);
        if (exp_rx.size() > 0) check("rx_word", 32'(bus.out), 32'(exp_rx.pop_front()));
      end
    end
    bus.empty = (tx_q.size() == 0);
    bus.in    = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    clk_wait(6);
  endtask

  task automatic cs_high();
    clk_wait(4);
    bus.spi_cs_n = 1'b1;
    clk_wait(8);
  endtask

  task automatic xfer_bits(input logic [7:0] d, input int nbits, output logic [7:0] m);
    m = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = d[7-i];
      clk_wait(4);
      bus.spi_clock = 1'b1;
      m = {m[6:0], bus.spi_miso};
      clk_wait(4);
      bus.spi_clock = 1'b0;
    end
  endtask

  task automatic send_word(input string tag, input logic [7:0] d, input logic [7:0] exp_miso);
    logic [7:0] m;
    if (!bus.full) exp_rx.push_back(d);
    check({tag, "_oe"}, 32'(bus.spi_miso_oe), 1);
    xfer_bits(d, 8, m);
    check({tag, "_miso"}, 32'(m), 32'(exp_miso));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_get"},      32'(bus.get), 0);
    check({tag, "_put"},      32'(bus.put), 0);
    check({tag, "_out"},      32'(bus.out), 0);
    check({tag, "_miso"},     32'(bus.spi_miso), 0);
    check({tag, "_miso_oe"},  32'(bus.spi_miso_oe), 0);
    check({tag, "_overrun"},  32'(bus.overrun), 0);
    check({tag, "_underrun"}, 32'(bus.underrun), 0);
  endtask

  initial begin
    int u0, g0, o0;
    logic [7:0] m;
    rst = 1'b1;
    bus.spi_cs_n  = 1'b1;
    bus.spi_clock = 1'b0;
    bus.spi_mosi  = 1'b0;
    bus.full      = 1'b0;
    clk_wait(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    clk_wait(8);

    // single word, TX A5, RX 3C; trailing boundary load finds no word
    u0 = n_under; g0 = n_get;
    tx_q.push_back(8'hA5);
    clk_wait(10);
    cs_low();
    send_word("t1", 8'h3C, 8'hA5);
    cs_high();
    check("t1_underruns", 32'(n_under - u0), 1);
    check("t1_gets", 32'(n_get - g0), 1);

    // two words in one select
    u0 = n_under; g0 = n_get;
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h34);
    clk_wait(10);
    cs_low();
    send_word("t2w0", 8'hF0, 8'h12);
    send_word("t2w1", 8'h0F, 8'h34);
    cs_high();
    check("t2_underruns", 32'(n_under - u0), 1);
    check("t2_gets", 32'(n_get - g0), 2);

    // empty TX FIFO: idle pattern shifted out
    u0 = n_under;
    cs_low();
    check("t3_underrun_at_select", 32'(n_under - u0), 1);
    send_word("t3", 8'h55, 8'hFF);
    cs_high();
    check("t3_underruns", 32'(n_under - u0), 2);

    // RX full: word dropped, then next word accepted
    o0 = n_over;
    cs_low();
    bus.full = 1'b1;
    send_word("t4full", 8'hAA, 8'hFF);
    check("t4_out_kept", 32'(bus.out), 32'h55);
    check("t4_overruns", 32'(n_over - o0), 1);
    bus.full = 1'b0;
    send_word("t4next", 8'h5A, 8'hFF);
    cs_high();
    check("t4_overruns_after", 32'(n_over - o0), 1);

    // deselect after 4 bits: partial word discarded, TX word lost
    tx_q.push_back(8'h77);
    tx_q.push_back(8'h99);
    clk_wait(10);
    cs_low();
    xfer_bits(8'hF0, 4, m);
    check("t5_partial_miso", 32'(m), 32'h07);
    cs_high();
    cs_low();
    send_word("t5", 8'h81, 8'h99);
    cs_high();

    // reset mid-word with cs low: no resume until reselected
    o0 = n_over;
    cs_low();
    xfer_bits(8'hE7, 3, m);
    rst = 1'b1;
    clk_wait(2);
    check_reset_outputs("t6_reset");
    rst = 1'b0;
    xfer_bits(8'hE7, 5, m);
    check("t6_oe_after_reset", 32'(bus.spi_miso_oe), 0);
    check("t6_out_after_reset", 32'(bus.out), 0);
    cs_high();
    cs_low();
    send_word("t6", 8'hC3, 8'hFF);
    cs_high();
    check("t6_overruns", 32'(n_over - o0), 0);

    clk_wait(10);
    check("rx_scoreboard_drained", 32'(exp_rx.size()), 0);
    check("tx_fifo_drained", 32'(tx_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
